// File: rtl/vga_pkg.sv
// Shared types for the pong video/game path.
//   game_state_t : encoding of the game-flow controller state (3 bits)
//   WINNER_*     : encodings of the winner output
//   has_won      : win test shared by both players' scoring paths
package vga_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    PAUSE     = 3'd4,
    GAME_OVER = 3'd5
  } game_state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // A saturated score ends the game even without a two-point lead,
  // otherwise a win-by-two match could stall forever at the ceiling.
  function automatic logic has_won(input int unsigned mine,
                                   input int unsigned other,
                                   input int unsigned winScore,
                                   input int unsigned maxScore,
                                   input logic        byTwo);
    if (mine >= maxScore) return 1'b1;
    if (mine < winScore)  return 1'b0;
    return !byTwo || (mine >= other + 32'd2);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter advanced by the frame-rate strobe.
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick_i      : one-cycle frame strobe, decrements the count
//   load_i      : load load_val_i (has priority over tick_i)
//   load_val_i  : value to load
//   freeze_i    : hold the count and suppress expiry
//   expired_o   : a tick arrived while the count was 1
module tick_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         freeze_i,
  output logic         expired_o
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: a load wins over a tick, so a tick in the loading cycle
  // is never counted against the new interval.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && !freeze_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = tick_i && !freeze_i && (count_q == W'(1));

endmodule

// File: rtl/game_fsm.sv
// Game-flow controller for pong: menu, serve countdown, rally, point pause,
// optional user pause and game over. Owns both scores, the serving side and
// the winner, and gates ball motion.
//   clk, rst_n           : clock, asynchronous active-low reset
//   timing_tick          : one-cycle frame strobe for the SERVE/POINT timer
//   start/restart/pause  : level buttons, rising edges act
//   point_p1/point_p2    : one-cycle scoring pulses
//   state                : current game_state_t
//   player1/2_score      : scores, saturating at 2**SCORE_W-1
//   serve_side           : 0 = serve toward player 2, 1 = toward player 1
//   ball_en              : high only in PLAY
//   winner               : WINNER_NONE / WINNER_P1 / WINNER_P2
// Optional feature macro: GAME_PAUSE_EN adds the PAUSE state.
module game_fsm
  import vga_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int SCORE_W     = 4,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 90,
  parameter int WIN_BY_TWO  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               timing_tick,
  input  logic               start,
  input  logic               restart,
  input  logic               pause,
  input  logic               point_p1,
  input  logic               point_p2,
  output game_state_t        state,
  output logic [SCORE_W-1:0] player1_score,
  output logic [SCORE_W-1:0] player2_score,
  output logic               serve_side,
  output logic               ball_en,
  output logic [1:0]         winner
);

  localparam int MAX_TICKS = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int TIMER_W   = $clog2(MAX_TICKS + 1);
  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_TICKS);
  localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  game_state_t        state_d, state_q;
  logic [SCORE_W-1:0] p1_d, p1_q, p2_d, p2_q;
  logic               serveSide_d, serveSide_q;
  logic [1:0]         winner_d, winner_q;
  logic               ballEn_q;

  logic startPrev_q, startEdge_q;
  logic restartPrev_q, restartEdge_q;
  logic pauseGo;

  logic               timerLoad;
  logic [TIMER_W-1:0] timerLoadVal;
  logic               timerFreeze;
  logic               timerExpired;

  logic [SCORE_W-1:0] p1Inc, p2Inc;
  logic               p1Wins, p2Wins;

  // Button edge detectors. The previous-level registers reset to 1 so a
  // button held through reset is seen as already pressed and gives no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startPrev_q   <= 1'b1;
      startEdge_q   <= 1'b0;
      restartPrev_q <= 1'b1;
      restartEdge_q <= 1'b0;
    end else begin
      startPrev_q   <= start;
      startEdge_q   <= start & ~startPrev_q;
      restartPrev_q <= restart;
      restartEdge_q <= restart & ~restartPrev_q;
    end
  end

`ifdef GAME_PAUSE_EN
  logic        pausePrev_q, pauseEdge_q;
  game_state_t saved_q;

  // Pause button edge detector, same scheme as start/restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pausePrev_q <= 1'b1;
      pauseEdge_q <= 1'b0;
    end else begin
      pausePrev_q <= pause;
      pauseEdge_q <= pause & ~pausePrev_q;
    end
  end

  assign pauseGo = pauseEdge_q &&
                   ((state_q == SERVE) || (state_q == PLAY) || (state_q == POINT));

  // Remember which state was interrupted so PAUSE can return to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saved_q <= MENU;
    end else if ((state_d == PAUSE) && (state_q != PAUSE)) begin
      saved_q <= state_q;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pauseGo      = 1'b0;
`endif

  // The timer only runs in SERVE and POINT, and stops in the cycle a pause
  // is taken so the remaining count survives the pause untouched.
  assign timerFreeze = !((state_q == SERVE) || (state_q == POINT)) || pauseGo;

  tick_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (timing_tick),
    .load_i     (timerLoad),
    .load_val_i (timerLoadVal),
    .freeze_i   (timerFreeze),
    .expired_o  (timerExpired)
  );

  assign p1Inc  = (p1_q == SCORE_MAX) ? p1_q : p1_q + SCORE_W'(1);
  assign p2Inc  = (p2_q == SCORE_MAX) ? p2_q : p2_q + SCORE_W'(1);
  assign p1Wins = has_won(32'(p1Inc), 32'(p2_q), 32'(WIN_SCORE), 32'(SCORE_MAX),
                          WIN_BY_TWO != 0);
  assign p2Wins = has_won(32'(p2Inc), 32'(p1_q), 32'(WIN_SCORE), 32'(SCORE_MAX),
                          WIN_BY_TWO != 0);

  // Next-state, score and winner logic. In PLAY a scoring pulse takes
  // priority over a pause edge in the same cycle so no point is lost.
  always_comb begin
    state_d      = state_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    serveSide_d  = serveSide_q;
    winner_d     = winner_q;
    timerLoad    = 1'b0;
    timerLoadVal = SERVE_LOAD;

    case (state_q)
      MENU: begin
        if (startEdge_q) begin
          p1_d      = '0;
          p2_d      = '0;
          winner_d  = WINNER_NONE;
          timerLoad = 1'b1;
          state_d   = SERVE;
        end
      end

      SERVE: begin
        if (pauseGo) begin
          state_d = PAUSE;
        end else if (timerExpired) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (point_p1 && point_p2) begin
          timerLoad    = 1'b1;
          timerLoadVal = POINT_LOAD;
          state_d      = POINT;
        end else if (point_p1) begin
          p1_d        = p1Inc;
          serveSide_d = 1'b0;
          if (p1Wins) begin
            winner_d = WINNER_P1;
            state_d  = GAME_OVER;
          end else begin
            timerLoad    = 1'b1;
            timerLoadVal = POINT_LOAD;
            state_d      = POINT;
          end
        end else if (point_p2) begin
          p2_d        = p2Inc;
          serveSide_d = 1'b1;
          if (p2Wins) begin
            winner_d = WINNER_P2;
            state_d  = GAME_OVER;
          end else begin
            timerLoad    = 1'b1;
            timerLoadVal = POINT_LOAD;
            state_d      = POINT;
          end
        end else if (pauseGo) begin
          state_d = PAUSE;
        end
      end

      POINT: begin
        if (pauseGo) begin
          state_d = PAUSE;
        end else if (timerExpired) begin
          timerLoad = 1'b1;
          state_d   = SERVE;
        end
      end

`ifdef GAME_PAUSE_EN
      PAUSE: begin
        if (pauseEdge_q || startEdge_q) begin
          state_d = saved_q;
        end
      end
`endif

      GAME_OVER: begin
        if (restartEdge_q) begin
          winner_d = WINNER_NONE;
          state_d  = MENU;
        end
      end

      default: begin
        state_d = MENU;
      end
    endcase
  end

  // Registered outputs; ball_en is derived from the next state so it
  // changes in the same cycle as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MENU;
      p1_q        <= '0;
      p2_q        <= '0;
      serveSide_q <= 1'b0;
      winner_q    <= WINNER_NONE;
      ballEn_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      serveSide_q <= serveSide_d;
      winner_q    <= winner_d;
      ballEn_q    <= (state_d == PLAY);
    end
  end

  assign state         = state_q;
  assign player1_score = p1_q;
  assign player2_score = p2_q;
  assign serve_side    = serveSide_q;
  assign ball_en       = ballEn_q;
  assign winner        = winner_q;

endmodule
